// File: rtl/x25519_pkg.sv
// Shared types, constants and the scalar clamp for the X25519 ladder.
package x25519_pkg;

    typedef enum logic [1:0] {
        DRAIN,
        IDLE,
        ISSUE,
        WAIT
    } ladder_state_t;

    localparam int unsigned LADDER_TOP_BIT = 254;
    localparam int unsigned FIELD_BITS     = 256;
    localparam int unsigned LIMB_BITS      = 264;

    // Clear the cofactor bits, clear bit 255 and force bit 254 high.
    function automatic logic [FIELD_BITS-1:0] x25519_clamp(input logic [FIELD_BITS-1:0] e);
        logic [FIELD_BITS-1:0] c;
        c      = e;
        c[2:0] = 3'b000;
        c[255] = 1'b0;
        c[254] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/x25519_ladder_controller.sv
// Montgomery-ladder sequencer: issues 255 iterations to an external core,
// scanning scalar bits 254..0 and feeding each (xzm, xzm1) result back.
module x25519_ladder_controller
    import x25519_pkg::*;
#(
    parameter bit          CLAMP_SCALAR = 1'b1,
    parameter int unsigned DRAIN_CYCLES = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [FIELD_BITS-1:0]   scalar,
    input  logic [LIMB_BITS-1:0]    work_low,
    output logic                    busy,
    output logic                    done,
    output logic [2*FIELD_BITS-1:0] xzm_out,
    output logic [2*FIELD_BITS-1:0] xzm1_out,
    output logic                    iter_en,
    output logic                    iter_b,
    output logic [2*FIELD_BITS-1:0] iter_xzm,
    output logic [2*FIELD_BITS-1:0] iter_xzm1,
    output logic [LIMB_BITS-1:0]    iter_work_low,
    input  logic                    iter_valid,
    input  logic [2*FIELD_BITS-1:0] iter_xzm_res,
    input  logic [2*FIELD_BITS-1:0] iter_xzm1_res
);

    localparam int unsigned           DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    ladder_state_t           state;
    logic [DRAIN_W-1:0]      drain_cnt;
    logic [7:0]              pos;
    logic [7:0]              pos_dec;
    logic [FIELD_BITS-1:0]   scalar_q;
    logic [FIELD_BITS-1:0]   scalar_sel;

    // Scalar as it will be latched on an accepted start, and the next bit position.
    always_comb begin
        scalar_sel = CLAMP_SCALAR ? x25519_clamp(scalar) : scalar;
        pos_dec    = pos - 8'd1;
    end

    // Ladder FSM with registered outputs. The cycle carrying done already sits in
    // IDLE, but done_q blocks acceptance so a start coincident with done is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= DRAIN;
            drain_cnt     <= '0;
            pos           <= '0;
            scalar_q      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            xzm_out       <= '0;
            xzm1_out      <= '0;
            iter_en       <= 1'b0;
            iter_b        <= 1'b0;
            iter_xzm      <= '0;
            iter_xzm1     <= '0;
            iter_work_low <= '0;
        end else begin
            iter_en <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                // Outlast any iteration the un-reset core may still have in flight.
                DRAIN: begin
                    busy <= 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    busy <= 1'b0;
                    if (start && !done) begin
                        scalar_q      <= scalar_sel;
                        iter_work_low <= work_low;
                        iter_xzm      <= {{FIELD_BITS{1'b0}}, FIELD_BITS'(1)};
                        iter_xzm1     <= {FIELD_BITS'(1), work_low[FIELD_BITS-1:0]};
                        pos           <= 8'(LADDER_TOP_BIT);
                        iter_b        <= scalar_sel[LADDER_TOP_BIT];
                        iter_en       <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (iter_valid) begin
                        iter_xzm  <= iter_xzm_res;
                        iter_xzm1 <= iter_xzm1_res;
                        if (pos == 8'd0) begin
                            xzm_out  <= iter_xzm_res;
                            xzm1_out <= iter_xzm1_res;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            pos     <= pos_dec;
                            iter_b  <= scalar_q[pos_dec];
                            iter_en <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                default: begin
                    state <= DRAIN;
                end
            endcase
        end
    end

endmodule
